// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch request/response and program-load bundle for imem_responder
interface imem_responder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [31:0] o_rsp_addr;
  logic        o_rsp_err;
  logic        i_wr_en;
  logic [31:0] i_wr_addr;
  logic [31:0] i_wr_data;

  modport slave (
    input  i_req_valid, i_req_addr, i_rsp_ready, i_wr_en, i_wr_addr, i_wr_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_addr, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_addr, i_rsp_ready, i_wr_en, i_wr_addr, i_wr_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_addr, o_rsp_err
  );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder with fixed-latency pipeline
// and in-order response FIFO; outstanding requests are capped at the FIFO depth.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned RSP_DEPTH   = 4
) (
  input logic             clk,
  input logic             i_rst_n,
  imem_responder_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW       = $clog2(RSP_DEPTH + 1);
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) << 2;
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(RSP_DEPTH);

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   req_off, wr_off;
  logic          req_err, wr_err;
  logic [AW-1:0] req_idx, wr_idx;

  logic [LATENCY-1:0] pipe_vld;
  logic [31:0]   pipe_data [LATENCY];
  logic [31:0]   pipe_addr [LATENCY];
  logic          pipe_err  [LATENCY];

  logic [31:0]   fifo_data [RSP_DEPTH];
  logic [31:0]   fifo_addr [RSP_DEPTH];
  logic          fifo_err  [RSP_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt, out_cnt;
  logic          ready_en;

  logic          rsp_valid, rsp_hs, req_ready, acc, fifo_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Offsets wrap at 32 bits, so addresses below BASE_ADDR land far out of range.
  assign req_off = bus.i_req_addr - BASE_ADDR;
  assign req_err = (req_off[1:0] != 2'b00) || ({1'b0, req_off} >= LIMIT);
  assign req_idx = req_off[AW+1:2];
  assign wr_off  = bus.i_wr_addr - BASE_ADDR;
  assign wr_err  = (wr_off[1:0] != 2'b00) || ({1'b0, wr_off} >= LIMIT);
  assign wr_idx  = wr_off[AW+1:2];

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_hs    = rsp_valid && bus.i_rsp_ready;
  assign req_ready = ready_en && ((out_cnt < MAX_CNT) || rsp_hs);
  assign acc       = bus.i_req_valid && req_ready;
  assign fifo_wr   = pipe_vld[LATENCY-1];

  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;
  assign bus.o_rsp_addr  = rsp_valid ? fifo_addr[rd_ptr] : '0;
  assign bus.o_rsp_err   = rsp_valid && fifo_err[rd_ptr];

  // Payload storage carries no reset; validity lives in the control block below.
  // The array read and write share an edge, so a same-edge fetch sees the old word.
  always_ff @(posedge clk) begin
    if (i_rst_n && bus.i_wr_en && !wr_err) begin
      mem[wr_idx] <= bus.i_wr_data;
    end
    if (acc) begin
      pipe_data[0] <= req_err ? 32'h0000_0000 : mem[req_idx];
      pipe_addr[0] <= bus.i_req_addr;
      pipe_err[0]  <= req_err;
    end
    for (int unsigned i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_addr[i] <= pipe_addr[i-1];
      pipe_err[i]  <= pipe_err[i-1];
    end
    if (fifo_wr) begin
      fifo_data[wr_ptr] <= pipe_data[LATENCY-1];
      fifo_addr[wr_ptr] <= pipe_addr[LATENCY-1];
      fifo_err[wr_ptr]  <= pipe_err[LATENCY-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      pipe_vld <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      out_cnt  <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      pipe_vld[0] <= acc;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
      if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (rsp_hs)  rd_ptr <= ptr_inc(rd_ptr);
      case ({fifo_wr, rsp_hs})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({acc, rsp_hs})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed self-checking bench for imem_responder
module tb_imem_responder;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  imem_responder_if bus0 ();
  imem_responder_if bus1 ();

  imem_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(2), .RSP_DEPTH(4)
  ) u_dut0 (
    .clk(clk), .i_rst_n(rst_n), .bus(bus0)
  );

  imem_responder #(
    .DEPTH_WORDS(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(2), .RSP_DEPTH(4)
  ) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [31:0] addr, input logic [31:0] data);
    if (sel) begin
      bus1.i_wr_en = 1'b1; bus1.i_wr_addr = addr; bus1.i_wr_data = data;
    end else begin
      bus0.i_wr_en = 1'b1; bus0.i_wr_addr = addr; bus0.i_wr_data = data;
    end
    step();
    bus0.i_wr_en = 1'b0;
    bus1.i_wr_en = 1'b0;
  endtask

  // Single fetch with rsp_ready high: response must be absent one cycle after
  // acceptance and present exactly LATENCY = 2 cycles after it.
  task automatic fetch_chk(input bit sel, input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic exp_err, input string tag);
    logic early_v;
    if (sel) begin
      bus1.i_rsp_ready = 1'b1; bus1.i_req_valid = 1'b1; bus1.i_req_addr = addr;
    end else begin
      bus0.i_rsp_ready = 1'b1; bus0.i_req_valid = 1'b1; bus0.i_req_addr = addr;
    end
    step();
    bus0.i_req_valid = 1'b0;
    bus1.i_req_valid = 1'b0;
    step();
    early_v = sel ? bus1.o_rsp_valid : bus0.o_rsp_valid;
    chk({tag, "_early"}, {31'b0, early_v}, 32'd0);
    step();
    chk({tag, "_valid"}, {31'b0, (sel ? bus1.o_rsp_valid : bus0.o_rsp_valid)}, 32'd1);
    chk({tag, "_data"}, sel ? bus1.o_rsp_data : bus0.o_rsp_data, exp_data);
    chk({tag, "_addr"}, sel ? bus1.o_rsp_addr : bus0.o_rsp_addr, addr);
    chk({tag, "_err"}, {31'b0, (sel ? bus1.o_rsp_err : bus0.o_rsp_err)}, {31'b0, exp_err});
  endtask

  initial begin
    logic [31:0] words [4];
    logic [31:0] rel_data [8];
    logic [31:0] rel_addr [8];
    words    = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    rel_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                 32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    rel_addr = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd12, 32'd8, 32'd4, 32'd0};
    n_total = 0;
    n_pass  = 0;

    rst_n = 1'b0;
    bus0.i_req_valid = 1'b0; bus0.i_req_addr = '0; bus0.i_rsp_ready = 1'b1;
    bus0.i_wr_en = 1'b0; bus0.i_wr_addr = '0; bus0.i_wr_data = '0;
    bus1.i_req_valid = 1'b0; bus1.i_req_addr = '0; bus1.i_rsp_ready = 1'b1;
    bus1.i_wr_en = 1'b0; bus1.i_wr_addr = '0; bus1.i_wr_data = '0;
    step();
    step();
    chk("rst_rsp_valid", {31'b0, bus0.o_rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus0.o_rsp_data, 32'd0);
    chk("rst_rsp_addr", bus0.o_rsp_addr, 32'd0);
    chk("rst_rsp_err", {31'b0, bus0.o_rsp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, bus0.o_req_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'b0, bus0.o_req_ready}, 32'd1);

    for (int i = 0; i < 4; i++) wr(1'b0, 32'(4 * i), words[i]);
    wr(1'b0, 32'h0000_0FFC, 32'hCAFE_F00D);
    wr(1'b0, 32'h0000_0005, 32'hBAD0_BAD0);
    wr(1'b0, 32'h0000_1000, 32'hBAD1_BAD1);

    // Back-to-back fetch of words 0..3; first response two edges after first accept.
    bus0.i_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus0.i_req_valid = (i < 4);
      bus0.i_req_addr  = 32'(4 * (i % 4));
      #1;
      if (i < 4) chk("b2b_ready", {31'b0, bus0.o_req_ready}, 32'd1);
      if (i >= 3 && i <= 6) begin
        chk("b2b_valid", {31'b0, bus0.o_rsp_valid}, 32'd1);
        chk("b2b_data", bus0.o_rsp_data, words[i-3]);
        chk("b2b_addr", bus0.o_rsp_addr, 32'(4 * (i - 3)));
        chk("b2b_err", {31'b0, bus0.o_rsp_err}, 32'd0);
      end else begin
        chk("b2b_idle", {31'b0, bus0.o_rsp_valid}, 32'd0);
      end
      step();
    end

    // Back-pressure: four accepts fill the outstanding budget, head holds steady.
    bus0.i_rsp_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      bus0.i_req_valid = 1'b1;
      bus0.i_req_addr  = 32'(4 * (j % 4));
      #1;
      chk("bp_ready", {31'b0, bus0.o_req_ready}, (j < 4) ? 32'd1 : 32'd0);
      if (j >= 3) begin
        chk("bp_hold_valid", {31'b0, bus0.o_rsp_valid}, 32'd1);
        chk("bp_hold_data", bus0.o_rsp_data, words[0]);
        chk("bp_hold_addr", bus0.o_rsp_addr, 32'd0);
      end
      step();
    end
    bus0.i_rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus0.i_req_valid = (k < 4);
      bus0.i_req_addr  = 32'(12 - 4 * (k % 4));
      #1;
      if (k < 4) chk("rel_ready", {31'b0, bus0.o_req_ready}, 32'd1);
      chk("rel_valid", {31'b0, bus0.o_rsp_valid}, 32'd1);
      chk("rel_data", bus0.o_rsp_data, rel_data[k]);
      chk("rel_addr", bus0.o_rsp_addr, rel_addr[k]);
      step();
    end
    bus0.i_req_valid = 1'b0;
    #1;
    chk("rel_drained", {31'b0, bus0.o_rsp_valid}, 32'd0);
    step();

    fetch_chk(1'b0, 32'h0000_0006, 32'h0, 1'b1, "err_misalign");
    fetch_chk(1'b0, 32'h0000_1000, 32'h0, 1'b1, "err_range");
    fetch_chk(1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, "last_word");
    fetch_chk(1'b0, 32'h0000_0004, 32'h2222_2222, 1'b0, "wr_misalign_ignored");
    fetch_chk(1'b0, 32'h0000_0000, 32'h1111_1111, 1'b0, "wr_range_ignored");

    wr(1'b1, 32'h8000_0004, 32'h55AA_55AA);
    fetch_chk(1'b1, 32'h8000_0004, 32'h55AA_55AA, 1'b0, "base_word1");
    fetch_chk(1'b1, 32'h7FFF_FFFC, 32'h0, 1'b1, "base_wrap");

    // Write and fetch of the same word on one edge, then a fetch one edge later.
    bus0.i_rsp_ready = 1'b1;
    bus0.i_wr_en = 1'b1; bus0.i_wr_addr = 32'd8; bus0.i_wr_data = 32'hDEAD_BEEF;
    bus0.i_req_valid = 1'b1; bus0.i_req_addr = 32'd8;
    step();
    bus0.i_wr_en = 1'b0;
    step();
    bus0.i_req_valid = 1'b0;
    step();
    chk("hz_old_valid", {31'b0, bus0.o_rsp_valid}, 32'd1);
    chk("hz_old_data", bus0.o_rsp_data, 32'h3333_3333);
    step();
    chk("hz_new_valid", {31'b0, bus0.o_rsp_valid}, 32'd1);
    chk("hz_new_data", bus0.o_rsp_data, 32'hDEAD_BEEF);
    step();
    chk("hz_drained", {31'b0, bus0.o_rsp_valid}, 32'd0);

    // Reset with three requests in flight; nothing stale may surface afterwards.
    bus0.i_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus0.i_req_valid = 1'b1;
      bus0.i_req_addr  = 32'(4 * i);
      step();
    end
    bus0.i_req_valid = 1'b0;
    step();
    step();
    chk("mid_pre_valid", {31'b0, bus0.o_rsp_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", {31'b0, bus0.o_rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, bus0.o_req_ready}, 32'd0);
    chk("mid_rst_data", bus0.o_rsp_data, 32'd0);
    rst_n = 1'b1;
    bus0.i_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_stale", {31'b0, bus0.o_rsp_valid}, 32'd0);
      if (i == 0) chk("mid_ready_back", {31'b0, bus0.o_req_ready}, 32'd1);
    end
    fetch_chk(1'b0, 32'h0000_0000, 32'h1111_1111, 1'b0, "mid_array_kept");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
